// File: rtl/data_mem_mmio.sv
// Data-port responder for the MIPS core: word-addressed RAM plus an MMIO page
// holding a cycle counter, a compare timer with sticky IRQ and a byte TX FIFO.
module data_mem_mmio #(
    parameter int          RAM_AW     = 8,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] MMIO_PAGE  = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] memaddr,
    input  logic [31:0] memwritedata,
    output logic [31:0] memreaddata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        irq
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [1:0] OFF_CYCLE   = 2'd0;
    localparam logic [1:0] OFF_TIMECMP = 2'd1;
    localparam logic [1:0] OFF_STATUS  = 2'd2;
    localparam logic [1:0] OFF_TXDATA  = 2'd3;

    logic [31:0]      ram_r [2**RAM_AW];
    logic [7:0]       fifo_mem_r [FIFO_DEPTH];
    logic [31:0]      cycle_r;
    logic [31:0]      timecmp_r;
    logic             timer_hit_r;
    logic             tx_overflow_r;
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;

    logic              mmio_page_s;
    logic              mmio_hit_s;
    logic [1:0]        offset_s;
    logic [RAM_AW-1:0] ram_idx_s;
    logic              ram_we_s;
    logic              timecmp_we_s;
    logic              status_we_s;
    logic              push_s;
    logic              push_ok_s;
    logic              pop_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              hit_set_s;
    logic [31:0]       status_s;

    // Address decode and write/push/pop strobes
    always_comb begin
        mmio_page_s  = (memaddr[31:16] == MMIO_PAGE);
        mmio_hit_s   = mmio_page_s && (memaddr[15:4] == 12'd0);
        offset_s     = memaddr[3:2];
        ram_idx_s    = memaddr[RAM_AW+1:2];
        ram_we_s     = memwrite && !mmio_page_s && !reset;
        timecmp_we_s = memwrite && mmio_hit_s && (offset_s == OFF_TIMECMP);
        status_we_s  = memwrite && mmio_hit_s && (offset_s == OFF_STATUS);
        push_s       = memwrite && mmio_hit_s && (offset_s == OFF_TXDATA);
        fifo_full_s  = (count_r == FULL_CNT);
        fifo_empty_s = (count_r == {CNT_W{1'b0}});
        // Acceptance looks only at the pre-edge count, so a full FIFO rejects even while popping.
        push_ok_s    = push_s && !fifo_full_s;
        pop_s        = !fifo_empty_s && tx_ready;
        hit_set_s    = (timecmp_r != 32'd0) && (cycle_r == timecmp_r);
        status_s       = 32'd0;
        status_s[0]    = timer_hit_r;
        status_s[1]    = fifo_full_s;
        status_s[2]    = fifo_empty_s;
        status_s[3]    = tx_overflow_r;
        status_s[7:4]  = 4'(count_r);
    end

    // Combinational load path
    always_comb begin
        memreaddata = 32'd0;
        if (mmio_page_s) begin
            if (mmio_hit_s) begin
                case (offset_s)
                    OFF_CYCLE:   memreaddata = cycle_r;
                    OFF_TIMECMP: memreaddata = timecmp_r;
                    OFF_STATUS:  memreaddata = status_s;
                    default:     memreaddata = 32'd0;
                endcase
            end else begin
                memreaddata = 32'd0;
            end
        end else begin
            memreaddata = ram_r[ram_idx_s];
        end
    end

    // FIFO head presentation and IRQ
    always_comb begin
        tx_valid = !fifo_empty_s;
        irq      = timer_hit_r;
        if (fifo_empty_s) begin
            tx_data = 8'h00;
        end else begin
            tx_data = fifo_mem_r[head_r];
        end
    end

    // RAM and FIFO storage arrays (never cleared)
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            ram_r[ram_idx_s] <= memwritedata;
        end
        if (push_ok_s && !reset) begin
            fifo_mem_r[tail_r] <= memwritedata[7:0];
        end
    end

    // Counter, timer, status flags and FIFO bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_r       <= 32'd0;
            timecmp_r     <= 32'd0;
            timer_hit_r   <= 1'b0;
            tx_overflow_r <= 1'b0;
            head_r        <= {PTR_W{1'b0}};
            tail_r        <= {PTR_W{1'b0}};
            count_r       <= {CNT_W{1'b0}};
        end else begin
            cycle_r <= cycle_r + 32'd1;
            if (timecmp_we_s) begin
                timecmp_r <= memwritedata;
            end
            // A new hit or overflow outranks a same-cycle W1C.
            timer_hit_r   <= hit_set_s || (timer_hit_r && !(status_we_s && memwritedata[0]));
            tx_overflow_r <= (push_s && fifo_full_s) ||
                             (tx_overflow_r && !(status_we_s && memwritedata[3]));
            if (push_ok_s) begin
                tail_r <= tail_r + PTR_W'(1);
            end
            if (pop_s) begin
                head_r <= head_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_mmio.sv
// Directed bench for data_mem_mmio: a queue/array model is checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_data_mem_mmio;
    localparam int RAM_AW = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memwrite = 1'b0;
    logic [31:0] memaddr = 32'd0;
    logic [31:0] memwritedata = 32'd0;
    logic [31:0] memreaddata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        irq;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    logic [31:0] m_cycle, m_timecmp;
    bit          m_hit, m_ovf;
    logic [7:0]  m_q [$];
    logic [31:0] m_ram [int];

    data_mem_mmio #(.RAM_AW(RAM_AW), .FIFO_DEPTH(8), .MMIO_PAGE(16'hFFFF)) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .memaddr(memaddr),
        .memwritedata(memwritedata), .memreaddata(memreaddata), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_status();
        int n = m_q.size();
        return {24'd0, 4'(n), m_ovf, (n == 0), (n == 8), m_hit};
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, output bit known);
        known = 1'b1;
        if (a[31:16] == 16'hFFFF) begin
            if (a[15:4] != 12'd0) return 32'd0;
            case (a[3:2])
                2'd0:    return m_cycle;
                2'd1:    return m_timecmp;
                2'd2:    return model_status();
                default: return 32'd0;
            endcase
        end
        if (m_ram.exists(int'(a[RAM_AW+1:2]))) return m_ram[int'(a[RAM_AW+1:2])];
        known = 1'b0;
        return 32'd0;
    endfunction

    // Apply the rules of one clock edge to the model, using pre-edge state and inputs.
    task automatic model_update();
        bit page, mapped, set_hit, clr_hit, clr_ovf, push, accept;
        int pre;
        page    = (memaddr[31:16] == 16'hFFFF);
        mapped  = page && (memaddr[15:4] == 12'd0);
        if (reset) begin
            m_cycle = 32'd0; m_timecmp = 32'd0; m_hit = 1'b0; m_ovf = 1'b0;
            m_q.delete();
        end else begin
            set_hit = (m_timecmp != 32'd0) && (m_cycle == m_timecmp);
            clr_hit = memwrite && mapped && (memaddr[3:2] == 2'd2) && memwritedata[0];
            clr_ovf = memwrite && mapped && (memaddr[3:2] == 2'd2) && memwritedata[3];
            push    = memwrite && mapped && (memaddr[3:2] == 2'd3);
            pre     = m_q.size();
            accept  = push && (pre < 8);
            if (memwrite && !page) m_ram[int'(memaddr[RAM_AW+1:2])] = memwritedata;
            if (memwrite && mapped && memaddr[3:2] == 2'd1) m_timecmp = memwritedata;
            if (pre > 0 && tx_ready) void'(m_q.pop_front());
            if (accept) m_q.push_back(memwritedata[7:0]);
            m_hit   = set_hit || (m_hit && !clr_hit);
            m_ovf   = (push && !accept) || (m_ovf && !clr_ovf);
            m_cycle = m_cycle + 32'd1;
        end
    endtask

    // Every-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        logic [31:0] exp_rd;
        bit known;
        if (chk_en) begin
            check("model_tx_valid", {31'd0, tx_valid}, {31'd0, m_q.size() != 0});
            check("model_tx_data", {24'd0, tx_data}, {24'd0, (m_q.size() != 0) ? m_q[0] : 8'h00});
            check("model_irq", {31'd0, irq}, {31'd0, m_hit});
            exp_rd = model_read(memaddr, known);
            if (known) check("model_rd", memreaddata, exp_rd);
        end
    end

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        memwrite = 1'b1; memaddr = a; memwritedata = d;
        tick();
        memwrite = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic expect_rd(input logic [31:0] a, input logic [31:0] exp, input string name);
        memaddr = a;
        #1;
        check(name, memreaddata, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        chk_en = 1'b1;
        check("reset_txv", {31'd0, tx_valid}, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        expect_rd(32'hFFFF_0008, 32'h0000_0004, "reset_status");

        // RAM store/load and aliasing
        wr(32'h0000_0010, 32'hDEAD_BEEF);
        expect_rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_rd");
        expect_rd(32'h0000_0410, 32'hDEAD_BEEF, "ram_alias");

        // Timer: match at CYCLE==20, W1C clear, then disabled
        do_reset();
        wr(32'hFFFF_0004, 32'd20);
        expect_rd(32'hFFFF_0000, 32'd1, "cycle_after_wr");
        idle(18);
        check("irq_before", {31'd0, irq}, 32'd0);
        idle(1);
        check("irq_at_edge20", {31'd0, irq}, 32'd0);
        idle(1);
        check("irq_set", {31'd0, irq}, 32'd1);
        expect_rd(32'hFFFF_0000, 32'd21, "cycle_21");
        wr(32'hFFFF_0008, 32'd1);
        check("irq_w1c", {31'd0, irq}, 32'd0);
        wr(32'hFFFF_0004, 32'd0);
        idle(100);
        check("irq_disabled", {31'd0, irq}, 32'd0);

        // FIFO fill past capacity, then drain
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) wr(32'hFFFF_000C, 32'h41 + i);
        expect_rd(32'hFFFF_0008, 32'h0000_008A, "full_status");
        for (int i = 0; i < 8; i++) begin
            tx_ready = 1'b1;
            check("drain_data", {24'd0, tx_data}, 32'h41 + i);
            tick();
        end
        check("drained_valid", {31'd0, tx_valid}, 32'd0);
        check("drained_data", {24'd0, tx_data}, 32'd0);
        wr(32'hFFFF_0008, 32'd8);
        expect_rd(32'hFFFF_0008, 32'h0000_0004, "ovf_cleared");

        // Push while full and popping: rejected
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) wr(32'hFFFF_000C, 32'h60 + i);
        tx_ready = 1'b1;
        wr(32'hFFFF_000C, 32'h55);
        expect_rd(32'hFFFF_0008, 32'h0000_0078, "full_pushpop_status");
        idle(7);
        check("empty_again", {31'd0, tx_valid}, 32'd0);
        wr(32'hFFFF_0008, 32'd8);

        // Push+pop at count 3 keeps the count and order
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) wr(32'hFFFF_000C, 32'h31 + i);
        tx_ready = 1'b1;
        wr(32'hFFFF_000C, 32'h55);
        expect_rd(32'hFFFF_0008, 32'h0000_0030, "pushpop_count3");
        check("order_0", {24'd0, tx_data}, 32'h32); tick();
        check("order_1", {24'd0, tx_data}, 32'h33); tick();
        check("order_2", {24'd0, tx_data}, 32'h55); tick();
        check("order_empty", {31'd0, tx_valid}, 32'd0);

        // Reset in the middle of activity, with a push held during reset
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) wr(32'hFFFF_000C, 32'h70 + i);
        wr(32'hFFFF_0004, m_cycle + 32'd2);
        idle(2);
        check("irq_pre_reset", {31'd0, irq}, 32'd1);
        reset = 1'b1; memwrite = 1'b1; memaddr = 32'hFFFF_000C; memwritedata = 32'h99;
        tick();
        reset = 1'b0; memwrite = 1'b0;
        check("rst_txv", {31'd0, tx_valid}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        expect_rd(32'hFFFF_0000, 32'd0, "rst_cycle");
        expect_rd(32'hFFFF_0008, 32'h0000_0004, "rst_status");
        tick();
        check("rst_no_push", {31'd0, tx_valid}, 32'd0);

        // Unmapped MMIO decode
        expect_rd(32'hFFFF_0010, 32'd0, "unmapped_10");
        expect_rd(32'hFFFF_0100, 32'd0, "unmapped_100");
        wr(32'hFFFF_0010, 32'hFFFF_FFFF);
        wr(32'hFFFF_0104, 32'h1234_5678);
        expect_rd(32'hFFFF_0004, 32'd0, "timecmp_untouched");
        expect_rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_untouched");
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
